gex_conductance_update_unit: RTL and testbench

//  Computes the next excitatory conductance sample fed to the EPSC datapath:

---
 rtl/gex_conductance_update_unit.sv | 199 +++++++++++++++++++
 tb/tb_gex_conductance_update_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gex_conductance_update_unit.sv
// gex_conductance_update_unit: next excitatory conductance sample
//   gexOut = gex - (gex*DeltaT)/Taugex + WeightSum   (signed fixed point)
// Sequence: IDLE -> MULT (1) -> DIV (DATA_WIDTH) -> ACC (1) -> DONE (1) -> IDLE.
// Optional build macro GEX_SATURATE_EN: saturating accumulate plus SatFlag output;
// without it the accumulate wraps modulo 2^DATA_WIDTH.
module gex_conductance_update_unit #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [DATA_WIDTH-1:0]    gex,
    input  logic [DATA_WIDTH-1:0]    WeightSum,
    input  logic [DELTAT_WIDTH-1:0]  DeltaT,
    input  logic [INTEGER_WIDTH-1:0] Taugex,
    output logic                     Busy,
    output logic                     Done,
    output logic                     DivZero,
`ifdef GEX_SATURATE_EN
    output logic                     SatFlag,
`endif
    output logic [DATA_WIDTH-1:0]    gexOut
);

    localparam int DW = DATA_WIDTH;
    localparam int IW = INTEGER_WIDTH;
    localparam int FW = DATA_WIDTH_FRAC;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_ACC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Operands captured when Start is accepted
    logic [DW-1:0]           gex_q;
    logic [DW-1:0]           ws_q;
    logic [DELTAT_WIDTH-1:0] dt_q;
    logic [IW-1:0]           tau_q;

    // Divider state: dvd_q shifts the dividend out and the quotient in
    logic [DW-1:0] dvd_q;
    logic [IW-1:0] rem_q;
    logic [IW-1:0] dvs_q;
    logic          neg_q;
    logic          dz_q;
    logic [CW-1:0] cnt_q;

    // Result registers
    logic [DW-1:0] gexout_q;
    logic          divzero_q;

    // Combinational datapath
    logic [DW-1:0]          dt_ext;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          pq;
    logic [DW-1:0]          pq_abs;
    logic [IW-1:0]          tau_abs;
    logic [IW:0]            rem_sh;
    logic [IW:0]            rem_sub;
    logic                   take;
    logic [DW-1:0]          quo;
    logic [DW-1:0]          acc;
`ifdef GEX_SATURATE_EN
    logic          satflag_q;
    logic [DW+1:0] acc_w;
    logic          sat;
`endif

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_MULT;
            S_MULT:  state_d = S_DIV;
            S_DIV:   if (cnt_q == CNT_LAST) state_d = S_ACC;
            S_ACC:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = (state_q != S_IDLE);
        Done = (state_q == S_DONE);
    end

    // Multiply, divider step and accumulate arithmetic
    always_comb begin
        // DeltaT sits just below the binary point: value = DeltaT * 2^-DELTAT_WIDTH
        dt_ext = '0;
        dt_ext[FW-1 -: DELTAT_WIDTH] = dt_q;
        prod    = $signed({{DW{gex_q[DW-1]}}, gex_q}) * $signed({{DW{1'b0}}, dt_ext});
        pq      = DW'(prod >>> FW);
        pq_abs  = pq[DW-1] ? -pq : pq;
        tau_abs = tau_q[IW-1] ? -tau_q : tau_q;

        rem_sh  = {rem_q, dvd_q[DW-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        take    = (rem_sh >= {1'b0, dvs_q});

        quo = dz_q ? '0 : (neg_q ? -dvd_q : dvd_q);

`ifdef GEX_SATURATE_EN
        // Two guard bits: three equal top bits means the sum fits in DW bits
        acc_w = {{2{gex_q[DW-1]}}, gex_q} - {{2{quo[DW-1]}}, quo} + {{2{ws_q[DW-1]}}, ws_q};
        sat   = !((acc_w[DW+1:DW-1] == 3'b000) || (acc_w[DW+1:DW-1] == 3'b111));
        if (!sat) begin
            acc = acc_w[DW-1:0];
        end else if (acc_w[DW+1]) begin
            acc = {1'b1, {(DW-1){1'b0}}};
        end else begin
            acc = {1'b0, {(DW-1){1'b1}}};
        end
`else
        acc = gex_q - quo + ws_q;
`endif
    end

    // Operand capture, divider iteration and result registration
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gex_q     <= '0;
            ws_q      <= '0;
            dt_q      <= '0;
            tau_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            gexout_q  <= '0;
            divzero_q <= 1'b0;
`ifdef GEX_SATURATE_EN
            satflag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        gex_q <= gex;
                        ws_q  <= WeightSum;
                        dt_q  <= DeltaT;
                        tau_q <= Taugex;
                    end
                end
                S_MULT: begin
                    dvd_q <= pq_abs;
                    rem_q <= '0;
                    dvs_q <= tau_abs;
                    neg_q <= pq[DW-1] ^ tau_q[IW-1];
                    dz_q  <= (tau_q == '0);
                    cnt_q <= '0;
                end
                S_DIV: begin
                    dvd_q <= {dvd_q[DW-2:0], take};
                    rem_q <= take ? IW'(rem_sub) : IW'(rem_sh);
                    cnt_q <= cnt_q + CW'(1);
                end
                S_ACC: begin
                    // Registered here so gexOut/DivZero are valid throughout the Done cycle
                    gexout_q  <= acc;
                    divzero_q <= dz_q;
`ifdef GEX_SATURATE_EN
                    satflag_q <= sat;
`endif
                end
                default: ;
            endcase
        end
    end

    assign gexOut  = gexout_q;
    assign DivZero = divzero_q;
`ifdef GEX_SATURATE_EN
    assign SatFlag = satflag_q;
`endif

endmodule

// File: tb/tb_gex_conductance_update_unit.sv
// Self-checking bench for gex_conductance_update_unit: vector table plus
// hand-written sequences for back-to-back, mid-op Start and reset abort.
module tb_gex_conductance_update_unit;

    localparam int IW  = 32;
    localparam int FW  = 32;
    localparam int DW  = 64;
    localparam int TW  = 4;
    localparam int LAT = DW + 3;
    localparam int NV  = 11;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [DW-1:0] gex;
    logic [DW-1:0] WeightSum;
    logic [TW-1:0] DeltaT;
    logic [IW-1:0] Taugex;
    logic          Busy;
    logic          Done;
    logic          DivZero;
    logic [DW-1:0] gexOut;
`ifdef GEX_SATURATE_EN
    logic          SatFlag;
`endif

    gex_conductance_update_unit #(
        .INTEGER_WIDTH  (IW),
        .DATA_WIDTH_FRAC(FW),
        .DATA_WIDTH     (DW),
        .DELTAT_WIDTH   (TW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .gex      (gex),
        .WeightSum(WeightSum),
        .DeltaT   (DeltaT),
        .Taugex   (Taugex),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
`ifdef GEX_SATURATE_EN
        .SatFlag  (SatFlag),
`endif
        .gexOut   (gexOut)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0] gex;
        logic [DW-1:0] ws;
        logic [TW-1:0] dt;
        logic [IW-1:0] tau;
        logic [DW-1:0] exp_out;
        logic          exp_dz;
        logic          exp_sat;
    } vec_t;

    typedef struct {
        vec_t        v;
        int unsigned start_cyc;
        int          id;
    } sb_t;

    vec_t vecs[NV];
    sb_t  sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every Done
    logic prev_done = 1'b0;
    always @(negedge Clock) begin : mon
        sb_t e;
        if (Reset) begin
            if (prev_done) begin
                check("Done one-cycle pulse", 64'(Done), 64'd0);
                check("Busy low after Done", 64'(Busy), 64'd0);
            end
            if (Done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected Done: gexOut 0x%016h with no op outstanding", gexOut);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("op%0d gexOut", e.id), gexOut, e.v.exp_out);
                    check($sformatf("op%0d DivZero", e.id), 64'(DivZero), 64'(e.v.exp_dz));
                    check($sformatf("op%0d latency", e.id), 64'(cyc - e.start_cyc + 1), 64'(LAT));
                    check($sformatf("op%0d Busy at Done", e.id), 64'(Busy), 64'd1);
`ifdef GEX_SATURATE_EN
                    check($sformatf("op%0d SatFlag", e.id), 64'(SatFlag), 64'(e.v.exp_sat));
`endif
                end
            end
        end
        prev_done = Done && Reset;
    end

    task automatic wait_idle();
        int unsigned k = 0;
        while (Busy && k < 200) begin
            @(negedge Clock);
            k++;
        end
        if (Busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: Busy still 1 after %0d cycles, required 0", k);
        end
    endtask

    // Issue one op; inputs are scrambled right after the sampling edge
    task automatic start_op(input vec_t v, input int id, input bit expect_done);
        @(negedge Clock);
        wait_idle();
        gex = v.gex; WeightSum = v.ws; DeltaT = v.dt; Taugex = v.tau;
        Start = 1'b1;
        @(negedge Clock);
        if (expect_done) sb_q.push_back('{v: v, start_cyc: cyc, id: id});
        check($sformatf("op%0d Busy after Start", id), 64'(Busy), 64'd1);
        Start = 1'b0;
        gex = ~v.gex; WeightSum = v.ws ^ 64'h5555_5555_5555_5555;
        DeltaT = ~v.dt; Taugex = v.tau + 32'd7;
    endtask

    task automatic drain();
        int unsigned k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(negedge Clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: %0d ops outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned c0;

        vecs[0]  = '{gex: 64'h0000_0001_0000_0000, ws: 64'h0, dt: 4'd8, tau: 32'd5,
                     exp_out: 64'h0000_0000_E666_6667, exp_dz: 1'b0, exp_sat: 1'b0};
        vecs[1]  = '{gex: 64'h0000_0001_0000_0000, ws: 64'h0000_0002_8000_0000, dt: 4'd8, tau: 32'd5,
                     exp_out: 64'h0000_0003_6666_6667, exp_dz: 1'b0, exp_sat: 1'b0};
        vecs[2]  = '{gex: 64'hFFFF_FFFF_0000_0000, ws: 64'h0, dt: 4'd8, tau: 32'd5,
                     exp_out: 64'hFFFF_FFFF_1999_9999, exp_dz: 1'b0, exp_sat: 1'b0};
        vecs[3]  = '{gex: 64'h0000_0001_0000_0000, ws: 64'h0000_0001_0000_0000, dt: 4'd8, tau: 32'd0,
                     exp_out: 64'h0000_0002_0000_0000, exp_dz: 1'b1, exp_sat: 1'b0};
`ifdef GEX_SATURATE_EN
        vecs[4]  = '{gex: 64'h7FFF_FFFF_0000_0000, ws: 64'h0000_0001_0000_0000, dt: 4'd0, tau: 32'd5,
                     exp_out: 64'h7FFF_FFFF_FFFF_FFFF, exp_dz: 1'b0, exp_sat: 1'b1};
`else
        vecs[4]  = '{gex: 64'h7FFF_FFFF_0000_0000, ws: 64'h0000_0001_0000_0000, dt: 4'd0, tau: 32'd5,
                     exp_out: 64'h8000_0000_0000_0000, exp_dz: 1'b0, exp_sat: 1'b0};
`endif
        vecs[5]  = '{gex: 64'h0000_0002_0000_0000, ws: 64'h0, dt: 4'd4, tau: 32'hFFFF_FFFE,
                     exp_out: 64'h0000_0002_4000_0000, exp_dz: 1'b0, exp_sat: 1'b0};
        vecs[6]  = '{gex: 64'h0000_0003_0000_0000, ws: 64'h0, dt: 4'd15, tau: 32'd3,
                     exp_out: 64'h0000_0002_1000_0000, exp_dz: 1'b0, exp_sat: 1'b0};
        vecs[7]  = '{gex: 64'hFFFF_FFFF_FFFF_FFFD, ws: 64'h0, dt: 4'd8, tau: 32'd1,
                     exp_out: 64'hFFFF_FFFF_FFFF_FFFF, exp_dz: 1'b0, exp_sat: 1'b0};
`ifdef GEX_SATURATE_EN
        vecs[8]  = '{gex: 64'h8000_0000_0000_0000, ws: 64'hFFFF_FFFF_0000_0000, dt: 4'd0, tau: 32'd7,
                     exp_out: 64'h8000_0000_0000_0000, exp_dz: 1'b0, exp_sat: 1'b1};
`else
        vecs[8]  = '{gex: 64'h8000_0000_0000_0000, ws: 64'hFFFF_FFFF_0000_0000, dt: 4'd0, tau: 32'd7,
                     exp_out: 64'h7FFF_FFFF_0000_0000, exp_dz: 1'b0, exp_sat: 1'b0};
`endif
        vecs[9]  = '{gex: 64'hFFFF_FFFF_0000_0000, ws: 64'h0000_0000_8000_0000, dt: 4'd15, tau: 32'd0,
                     exp_out: 64'hFFFF_FFFF_8000_0000, exp_dz: 1'b1, exp_sat: 1'b0};
        vecs[10] = '{gex: 64'h0000_0000_0000_0010, ws: 64'h0, dt: 4'd8, tau: 32'd1,
                     exp_out: 64'h0000_0000_0000_0008, exp_dz: 1'b0, exp_sat: 1'b0};

        Reset = 1'b1; Start = 1'b0;
        gex = '0; WeightSum = '0; DeltaT = '0; Taugex = '0;
        #3 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset DivZero", 64'(DivZero), 64'd0);
        check("reset gexOut", gexOut, 64'd0);
`ifdef GEX_SATURATE_EN
        check("reset SatFlag", 64'(SatFlag), 64'd0);
`endif
        Reset = 1'b1;

        // Table-driven single ops
        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i], i, 1'b1);
            drain();
        end

        // Start held high: second op restarts DATA_WIDTH+4 cycles later with new inputs
        @(negedge Clock);
        wait_idle();
        gex = vecs[0].gex; WeightSum = vecs[0].ws; DeltaT = vecs[0].dt; Taugex = vecs[0].tau;
        Start = 1'b1;
        @(negedge Clock);
        c0 = cyc;
        sb_q.push_back('{v: vecs[0], start_cyc: c0, id: 100});
        sb_q.push_back('{v: vecs[1], start_cyc: c0 + DW + 4, id: 101});
        gex = vecs[1].gex; WeightSum = vecs[1].ws; DeltaT = vecs[1].dt; Taugex = vecs[1].tau;
        while (cyc != c0 + DW + 4) @(negedge Clock);
        Start = 1'b0;
        drain();

        // Start during an op (cycle 10) must be ignored
        start_op(vecs[2], 200, 1'b1);
        repeat (9) @(negedge Clock);
        gex = vecs[0].gex; WeightSum = vecs[0].ws; DeltaT = vecs[0].dt; Taugex = vecs[0].tau;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        drain();
        repeat (80) @(negedge Clock);

        // Reset at cycle 30 aborts the op; outputs clear; next op has full latency
        start_op(vecs[3], 300, 1'b1);
        drain();
        start_op(vecs[0], 301, 1'b0);
        repeat (29) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        check("abort Busy", 64'(Busy), 64'd0);
        check("abort Done", 64'(Done), 64'd0);
        check("abort DivZero", 64'(DivZero), 64'd0);
        check("abort gexOut", gexOut, 64'd0);
        repeat (2) @(negedge Clock);
        check("abort gexOut held", gexOut, 64'd0);
        Reset = 1'b1;
        start_op(vecs[5], 302, 1'b1);
        drain();
        repeat (80) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
